alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the WISC execute-stage ALU. Generalises data width and adds an iterative multiply.
- Registers its result and the Z/V/N flag register.
- Folds the byte-load (LLB/LHB) path into the same opcode decode.
- Sits between decode and writeback. Decode drives operands with a valid/ready handshake; writeback consumes a one-cycle result pulse.

Parameters:
- DATA_W, 16, operand/result width; must be ≥16 and a power of 2.
- SAT_EN, 1, 1 = ADD/SUB saturate to signed max/min; 0 = wrap.
- SHAMT_W, $clog2(DATA_W), number of alu_in2 LSBs used as the shift/rotate amount.

Ports:
- clk in 1: clock; all state updates on rising edge.
- rst in 1: synchronous, active-low reset.
- in_valid in 1: operation offered.
- in_ready out 1: block can accept an operation this cycle.
- opcode in 4: operation select.
- alu_in1 in DATA_W: operand A (byte source for LLB/LHB).
- alu_in2 in DATA_W: operand B (insertion target for LLB/LHB).
- kill in 1: abort an in-flight multiply.
- out_valid out 1: one-cycle pulse, alu_out valid.
- alu_out out DATA_W: registered result.
- Z out 1: zero flag (registered).
- V out 1: overflow flag (registered).
- N out 1: negative flag (registered).
- busy out 1: multiply in progress.

Behaviour:
- Reset (rst==0 at edge): state IDLE; alu_out=0, out_valid=0, Z=V=N=0, busy=0, in_ready=1; multiply counter and accumulator cleared. Reset mid-multiply discards the operation, with no out_valid and no flag update.
- Accept condition: in_valid && in_ready at a rising edge; operands and opcode are sampled there.
- Opcode map:
  - 0000 ADD; 0001 SUB (A−B); 0010 XOR; 0011 AND.
  - 0100 SLL by B[SHAMT_W-1:0]; 0101 SRA; 0110 ROR.
  - 0111 MUL (unsigned, low DATA_W bits).
  - 1010 LLB: out = {B[DATA_W-1:8], A[7:0]}.
  - 1011 LHB: out = {A[7:0], B[DATA_W-9:0]}.
  - 1000, 1001, 11xx reserved: out = 0, flags unchanged, out_valid still pulses.
- State machine: IDLE, MUL.
  - IDLE, non-MUL accept: result and flags registered at the accept edge; out_valid=1 the next cycle (latency 1). State stays IDLE with in_ready=1, so back-to-back ops issue every cycle.
  - IDLE, MUL accept: go to MUL; in_ready=0, busy=1. Shift-add one bit per cycle with a counter from DATA_W-1 down to 0.
  - MUL completion: when the counter reaches 0, register the result and flags, return to IDLE, and pulse out_valid. out_valid is seen exactly DATA_W cycles after the accept edge. in_ready returns to 1 in the same cycle out_valid pulses.
  - MUL with kill=1: return to IDLE next edge; no out_valid; flags and alu_out hold their previous values.
  - IDLE with kill=1: no effect. kill does not block a same-cycle accept in IDLE.
- ADD/SUB:
  - V = signed overflow of the true result.
  - SAT_EN=1 with overflow: out = 0x7FF…F for positive overflow, 0x800…0 for negative overflow.
  - N = MSB of the written result; Z = (written result == 0).
  - All of Z, V, N update.
- XOR/AND/SLL/SRA/ROR: only Z updates; V and N hold.
- MUL: Z = (low half == 0); V = (upper DATA_W product bits != 0); N holds.
- LLB/LHB and reserved opcodes: no flag update.
- Shift amount 0 returns A unchanged. ROR wraps modulo DATA_W.
- out_valid has no backpressure; writeback must always consume it.
- alu_out holds its last value when out_valid=0.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD…OP_LHB);
  - state encoding (S_IDLE, S_MUL);
  - helper function for saturation limits.
- One sub-module, alu_mul_iter: iterative shift-add multiplier.
  - Inputs: start, kill, a, b.
  - Outputs: done, prod_lo, prod_hi_nz.
  - The top level owns the handshake, combinational ops, and the flag register.

Test Plan (DATA_W=16, SAT_EN=1):
- Reset: rst=0 for 2 cycles, then 1 → alu_out=0x0000, Z=V=N=0, in_ready=1, out_valid=0.
- Saturating ADD: ADD 0x7FFF+0x0001 → next cycle out_valid=1, alu_out=0x7FFF, V=1, N=0, Z=0.
- Negative saturation then flag hold:
  - SUB 0x8000−0x0001 → alu_out=0x8000, V=1, N=1.
  - Then XOR 0x00FF^0x00FF → alu_out=0, Z=1, V=1 and N=1 held.
- Multiply latency and handshake: MUL 0x0100×0x0101 → in_ready=0 for 16 cycles; out_valid on cycle 16 after accept, alu_out=0x0100, V=1, Z=0; back-to-back ADD the following cycle accepted.
- Kill mid-multiply: MUL 3×5, assert kill on cycle 5 → no out_valid, alu_out and flags unchanged, in_ready=1 next cycle.
- Byte loads and shifts:
  - LLB A=0x12AB, B=0xCDEF → 0xCDAB.
  - LHB same operands → 0xABEF, flags unchanged.
  - ROR 0x0001 by 1 → 0x8000.
  - SRA 0x8000 by 15 → 0xFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and saturation helper for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_LHB = 4'b1011;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  localparam int unsigned SAT_MAX_W = 128;

  // Signed min (neg=1) or max (neg=0) for a w-bit word; callers cast to width.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input logic neg, input int unsigned w);
    logic [SAT_MAX_W-1:0] one;
    logic [SAT_MAX_W-1:0] s_min;
    one   = SAT_MAX_W'(1);
    s_min = one << (w - 1);
    return neg ? s_min : (s_min - one);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
module alu_mul_iter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kill,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] prod_lo,
  output logic              prod_hi_nz
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic                  run_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W-1:0]   mcand_q;
  logic [DATA_W-1:0]     mplier_q;
  logic [2*DATA_W-1:0]   acc_q;
  logic [2*DATA_W-1:0]   acc_d;

  // Product is taken from the accumulator's next value so the final bit
  // lands in the same edge that the top level registers the result.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done       = run_q && !kill && (cnt_q == '0);
  assign prod_lo    = acc_d[DATA_W-1:0];
  assign prod_hi_nz = |acc_d[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= CNT_W'(DATA_W - 1);
      mcand_q  <= {{DATA_W{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
    end else if (run_q) begin
      if (kill || (cnt_q == '0)) begin
        run_q <= 1'b0;
      end
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result/flags and iterative multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter bit          SAT_EN  = 1'b1,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] alu_in1,
  input  logic [DATA_W-1:0] alu_in2,
  input  logic              kill,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_out,
  output logic              Z,
  output logic              V,
  output logic              N,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              z_q, z_d, v_q, v_d, n_q, n_d;

  logic              accept, mul_start, mul_done, mul_hi_nz;
  logic [DATA_W-1:0] mul_lo;
  logic [SHAMT_W-1:0] sh;
  logic [DATA_W:0]   sum_x, dif_x;
  logic              add_ovf, sub_ovf;
  logic [DATA_W-1:0] add_res, sub_res;
  logic [DATA_W-1:0] op_res;
  logic              upd_z, upd_vn, op_v;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);
  assign sh        = alu_in2[SHAMT_W-1:0];

  alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (mul_start),
    .kill       (kill),
    .a          (alu_in1),
    .b          (alu_in2),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );

  // Sign-extended add/sub: overflow direction follows operand A's sign.
  always_comb begin
    sum_x   = {alu_in1[DATA_W-1], alu_in1} + {alu_in2[DATA_W-1], alu_in2};
    dif_x   = {alu_in1[DATA_W-1], alu_in1} - {alu_in2[DATA_W-1], alu_in2};
    add_ovf = sum_x[DATA_W] ^ sum_x[DATA_W-1];
    sub_ovf = dif_x[DATA_W] ^ dif_x[DATA_W-1];
    add_res = (SAT_EN && add_ovf) ? DATA_W'(sat_limit(alu_in1[DATA_W-1], DATA_W))
                                  : sum_x[DATA_W-1:0];
    sub_res = (SAT_EN && sub_ovf) ? DATA_W'(sat_limit(alu_in1[DATA_W-1], DATA_W))
                                  : dif_x[DATA_W-1:0];
  end

  always_comb begin
    op_res = '0;
    upd_z  = 1'b0;
    upd_vn = 1'b0;
    op_v   = 1'b0;
    case (opcode)
      OP_ADD: begin op_res = add_res; upd_z = 1'b1; upd_vn = 1'b1; op_v = add_ovf; end
      OP_SUB: begin op_res = sub_res; upd_z = 1'b1; upd_vn = 1'b1; op_v = sub_ovf; end
      OP_XOR: begin op_res = alu_in1 ^ alu_in2; upd_z = 1'b1; end
      OP_AND: begin op_res = alu_in1 & alu_in2; upd_z = 1'b1; end
      OP_SLL: begin op_res = alu_in1 << sh; upd_z = 1'b1; end
      OP_SRA: begin op_res = $unsigned($signed(alu_in1) >>> sh); upd_z = 1'b1; end
      OP_ROR: begin op_res = DATA_W'({alu_in1, alu_in1} >> sh); upd_z = 1'b1; end
      OP_LLB: op_res = {alu_in2[DATA_W-1:8], alu_in1[7:0]};
      OP_LHB: op_res = {alu_in1[7:0], alu_in2[DATA_W-9:0]};
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = 1'b0;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            valid_d = 1'b1;
            out_d   = op_res;
            if (upd_z) z_d = ~|op_res;
            if (upd_vn) begin
              v_d = op_v;
              n_d = op_res[DATA_W-1];
            end
          end
        end
      end
      S_MUL: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (mul_done) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          out_d   = mul_lo;
          z_d     = ~|mul_lo;
          v_d     = mul_hi_nz;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_out   = out_q;
  assign Z         = z_q;
  assign V         = v_q;
  assign N         = n_q;

endmodule
